// File: rtl/ps2_key_serializer.sv
// PS/2 device-to-host serializer: expands hps_io ps2_key toggle events into
// Set-2 bytes, queues them, and shifts them out as 11-bit frames.
module ps2_key_serializer #(
    parameter int CLK_HALF   = 1145,
    parameter int GAP_CYCLES = 2290,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic [10:0]                 ps2_key,
    output logic                        ps2_clk,
    output logic                        ps2_data,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (GAP_CYCLES > CLK_HALF) ? GAP_CYCLES : CLK_HALF;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        BIT_HI = 3'd2,
        BIT_LO = 3'd3,
        GAP    = 3'd4
    } state_t;

    logic          r_primed;
    logic          r_prev_toggle;
    logic          r_evt_valid;
    logic          r_evt_ext;
    logic          r_evt_rel;
    logic [7:0]    r_evt_code;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    r_bit;
    logic [3:0]    w_bit_nxt;
    logic [10:0]   r_frame;
    logic [10:0]   w_frame_nxt;
    logic          r_ps2_clk;
    logic          w_ps2_clk_nxt;
    logic          r_ps2_data;
    logic          w_ps2_data_nxt;

    logic [1:0]    w_n;
    logic [AW:0]   w_n_ext;
    logic [AW:0]   w_free;
    logic          w_fits;
    logic          w_wr;
    logic          w_pop;
    logic [7:0]    w_b0;
    logic [7:0]    w_b1;
    logic [7:0]    w_b2;
    logic [7:0]    w_pop_byte;

    // The first cycle out of reset only latches the toggle, so a stale level is not an event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_primed      <= 1'b0;
            r_prev_toggle <= 1'b0;
            r_evt_valid   <= 1'b0;
            r_evt_ext     <= 1'b0;
            r_evt_rel     <= 1'b0;
            r_evt_code    <= 8'h00;
        end else begin
            r_primed      <= 1'b1;
            r_prev_toggle <= ps2_key[10];
            r_evt_valid   <= r_primed && (ps2_key[10] != r_prev_toggle);
            r_evt_ext     <= ps2_key[8];
            r_evt_rel     <= ~ps2_key[9];
            r_evt_code    <= ps2_key[7:0];
        end
    end

    assign w_n     = 2'd1 + {1'b0, r_evt_ext} + {1'b0, r_evt_rel};
    assign w_n_ext = (AW+1)'(w_n);
    assign w_free  = DEPTH_W - r_count;
    assign w_fits  = (w_free >= w_n_ext);
    assign w_wr    = r_evt_valid & w_fits;
    assign w_pop   = (r_state == IDLE) && (r_count != '0);

    always_comb begin
        w_b0 = r_evt_code;
        w_b1 = 8'h00;
        w_b2 = 8'h00;
        case ({r_evt_ext, r_evt_rel})
            2'b11: begin
                w_b0 = 8'hE0;
                w_b1 = 8'hF0;
                w_b2 = r_evt_code;
            end
            2'b10: begin
                w_b0 = 8'hE0;
                w_b1 = r_evt_code;
            end
            2'b01: begin
                w_b0 = 8'hF0;
                w_b1 = r_evt_code;
            end
            default: ;
        endcase
    end

    // Whole prefix+code sequence lands in one cycle so a partial key never reaches the host.
    always_ff @(posedge clk_sys) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_b0;
            if (w_n >= 2'd2) begin
                r_mem[r_wr_ptr + AW'(1)] <= w_b1;
            end
            if (w_n == 2'd3) begin
                r_mem[r_wr_ptr + AW'(2)] <= w_b2;
            end
        end
    end

    assign w_pop_byte = r_mem[r_rd_ptr];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_evt_valid & ~w_fits;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(w_n);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (w_wr ? w_n_ext : '0) - (w_pop ? (AW+1)'(1) : '0);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= 4'd0;
            r_frame    <= 11'h7FF;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_frame    <= w_frame_nxt;
            r_ps2_clk  <= w_ps2_clk_nxt;
            r_ps2_data <= w_ps2_data_nxt;
        end
    end

    // Data only moves on the entry into a high phase, so it is stable across every low pulse.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + CW'(1);
        w_bit_nxt      = r_bit;
        w_frame_nxt    = r_frame;
        w_ps2_clk_nxt  = r_ps2_clk;
        w_ps2_data_nxt = r_ps2_data;
        case (r_state)
            IDLE: begin
                w_cnt_nxt      = '0;
                w_ps2_clk_nxt  = 1'b1;
                w_ps2_data_nxt = 1'b1;
                if (w_pop) begin
                    w_frame_nxt    = {1'b1, ~^w_pop_byte, w_pop_byte, 1'b0};
                    w_bit_nxt      = 4'd0;
                    w_ps2_data_nxt = w_frame_nxt[0];
                    w_state_nxt    = LOAD;
                end
            end
            LOAD, BIT_HI: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt     = '0;
                    w_ps2_clk_nxt = 1'b0;
                    w_state_nxt   = BIT_LO;
                end
            end
            BIT_LO: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt     = '0;
                    w_ps2_clk_nxt = 1'b1;
                    if (r_bit == 4'd10) begin
                        w_ps2_data_nxt = 1'b1;
                        w_state_nxt    = GAP;
                    end else begin
                        w_bit_nxt      = r_bit + 4'd1;
                        w_ps2_data_nxt = r_frame[r_bit + 4'd1];
                        w_state_nxt    = BIT_HI;
                    end
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_cnt_nxt      = '0;
                w_ps2_clk_nxt  = 1'b1;
                w_ps2_data_nxt = 1'b1;
                w_state_nxt    = IDLE;
            end
        endcase
    end

    assign ps2_clk    = r_ps2_clk;
    assign ps2_data   = r_ps2_data;
    assign overflow   = r_overflow;
    assign fifo_level = r_count;
    assign busy       = (r_count != '0) | (r_state != IDLE);

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Bench for ps2_key_serializer: a byte-queue/frame-timeline model checked every
// cycle, plus a serial receiver whose decoded frames are pinned to literals.
module tb_ps2_key_serializer;

    localparam int H         = 4;
    localparam int GAPC      = 8;
    localparam int DEPTH     = 16;
    localparam int FRAME_LEN = 22 * H + GAPC;

    logic        clk_sys;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        ps2_clk;
    logic        ps2_data;
    logic        busy;
    logic        overflow;
    logic [4:0]  fifo_level;

    ps2_key_serializer #(
        .CLK_HALF  (H),
        .GAP_CYCLES(GAPC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .busy      (busy),
        .overflow  (overflow),
        .fifo_level(fifo_level)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    int errCount   = 0;
    int checkCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAtLeast(input string name, input int actual, input int minimum);
        checkCount++;
        if (actual < minimum) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected at least %0d", name, actual, minimum);
        end
    endtask

    // Model: bytes waiting, plus the position inside the current frame (-1 when idle).
    logic [7:0] mQ[$];
    int         mTimer    = -1;
    logic [7:0] mCur      = 8'h00;
    logic       mOverflow = 1'b0;
    logic       mPrimed   = 1'b0;
    logic       mPrev     = 1'b0;
    logic       mEvtValid = 1'b0;
    logic       mEvtExt   = 1'b0;
    logic       mEvtRel   = 1'b0;
    logic [7:0] mEvtCode  = 8'h00;

    task automatic modelReset();
        mQ.delete();
        mTimer    = -1;
        mOverflow = 1'b0;
        mPrimed   = 1'b0;
        mPrev     = 1'b0;
        mEvtValid = 1'b0;
    endtask

    task automatic modelStep();
        int oldCount;
        int n;
        oldCount  = mQ.size();
        mOverflow = 1'b0;
        if (mTimer < 0) begin
            if (oldCount > 0) begin
                mCur   = mQ.pop_front();
                mTimer = 0;
            end
        end else begin
            mTimer++;
            if (mTimer == FRAME_LEN) mTimer = -1;
        end
        if (mEvtValid) begin
            n = 1 + int'(mEvtExt) + int'(mEvtRel);
            if (DEPTH - oldCount >= n) begin
                if (mEvtExt) mQ.push_back(8'hE0);
                if (mEvtRel) mQ.push_back(8'hF0);
                mQ.push_back(mEvtCode);
            end else begin
                mOverflow = 1'b1;
            end
        end
        mEvtValid = mPrimed && (ps2_key[10] != mPrev);
        mEvtExt   = ps2_key[8];
        mEvtRel   = !ps2_key[9];
        mEvtCode  = ps2_key[7:0];
        mPrev     = ps2_key[10];
        mPrimed   = 1'b1;
    endtask

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) modelReset();
        else          modelStep();
    end

    function automatic logic frameBit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9) return ($countones(b) % 2) == 0;
        return 1'b1;
    endfunction

    function automatic logic expClk();
        if (mTimer < H || mTimer >= 22 * H) return 1'b1;
        return (((mTimer - H) / H) % 2) == 1;
    endfunction

    function automatic logic expData();
        int k;
        if (mTimer < 0 || mTimer >= 22 * H) return 1'b1;
        if (mTimer < H) return frameBit(mCur, 0);
        k = (mTimer - H) / H;
        return frameBit(mCur, (k + 1) / 2);
    endfunction

    logic [10:0] rxFrames[$];
    logic [10:0] rxShift        = 11'h000;
    int          rxBits         = 0;
    int          lowLen         = 0;
    int          pulseCount     = 0;
    int          cycleCnt       = 0;
    int          lastStopCycle  = 0;
    bit          haveStop       = 1'b0;
    logic        prevClk        = 1'b1;
    int          busyHighCnt    = 0;
    int          overflowSeen   = 0;
    int          peakLevel      = 0;

    always @(negedge clk_sys) begin
        cycleCnt++;
        checkOutput("ps2_clk", ps2_clk, expClk());
        checkOutput("ps2_data", ps2_data, expData());
        checkOutput("busy", busy, (mQ.size() != 0) || (mTimer >= 0));
        checkOutput("overflow", overflow, mOverflow);
        checkOutput("fifo_level", fifo_level, mQ.size());
        if (busy) busyHighCnt++;
        if (overflow) overflowSeen++;
        if (int'(fifo_level) > peakLevel) peakLevel = int'(fifo_level);
        if (!reset_n) begin
            rxBits   = 0;
            lowLen   = 0;
            haveStop = 1'b0;
            prevClk  = 1'b1;
        end else begin
            if (prevClk && !ps2_clk) begin
                if (rxBits == 0 && haveStop) checkAtLeast("frameGap", cycleCnt - lastStopCycle, GAPC);
                if (rxBits < 11) rxShift[rxBits] = ps2_data;
                rxBits++;
                lowLen = 1;
            end else if (!ps2_clk) begin
                lowLen++;
            end else if (!prevClk && ps2_clk) begin
                checkOutput("lowPulseLen", lowLen, H);
                pulseCount++;
                if (rxBits >= 11) begin
                    rxFrames.push_back(rxShift);
                    rxBits        = 0;
                    haveStop      = 1'b1;
                    lastStopCycle = cycleCnt;
                end
            end
            prevClk = ps2_clk;
        end
    end

    logic tog = 1'b1;
    logic [10:0] expFrames [6] = '{11'h438, 11'h5C0, 11'h4EA, 11'h5C0, 11'h7E0, 11'h4EA};

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [10:0] key);
        ps2_key = key;
        waitCycles(1);
    endtask

    task automatic sendEvent(input logic pressed, input logic ext, input logic [7:0] code);
        tog = ~tog;
        applyStimulus({tog, pressed, ext, code});
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) break;
            waitCycles(1);
        end
        checkOutput("waitIdle", busy, 1'b0);
    endtask

    task automatic waitTimer(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (mTimer == target) break;
            waitCycles(1);
        end
        checkOutput("waitTimer", mTimer, target);
    endtask

    int rxBase;

    initial begin
        ps2_key = 11'h400;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        waitCycles(3);
        reset_n = 1'b1;

        $display("[TB] toggle already set at reset release");
        busyHighCnt = 0;
        waitCycles(40);
        checkOutput("staleToggleBusy", busyHighCnt, 0);
        checkOutput("staleToggleRx", rxFrames.size(), 0);

        $display("[TB] single key then extended make+break");
        pulseCount = 0;
        peakLevel  = 0;
        sendEvent(1'b1, 1'b0, 8'h1C);
        waitCycles(8);
        sendEvent(1'b1, 1'b1, 8'h75);
        sendEvent(1'b0, 1'b1, 8'h75);
        waitIdle(2000);
        checkOutput("rxFrameCount", rxFrames.size(), 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("rxFrame%0d", i), (rxFrames.size() > i) ? rxFrames[i] : 11'h000, expFrames[i]);
        end
        checkOutput("lowPulses", pulseCount, 66);
        checkOutput("peakLevel", peakLevel, 5);

        $display("[TB] overflow while serializer busy");
        rxBase       = rxFrames.size();
        overflowSeen = 0;
        sendEvent(1'b1, 1'b0, 8'h1C);
        waitCycles(5);
        repeat (6) sendEvent(1'b0, 1'b1, 8'h74);
        sendEvent(1'b1, 1'b0, 8'h29);
        waitCycles(2);
        checkOutput("levelFull", fifo_level, 16);
        checkOutput("overflowPulses", overflowSeen, 1);
        waitIdle(3000);
        checkOutput("overflowRxCount", rxFrames.size() - rxBase, 17);

        $display("[TB] pop and 3-byte write in the same cycle");
        rxBase = rxFrames.size();
        sendEvent(1'b1, 1'b0, 8'h16);
        waitCycles(3);
        repeat (4) sendEvent(1'b0, 1'b1, 8'h11);
        sendEvent(1'b1, 1'b0, 8'h0E);
        waitCycles(2);
        checkOutput("levelThirteen", fifo_level, 13);
        waitTimer(FRAME_LEN - 1, 200);
        sendEvent(1'b0, 1'b1, 8'h12);
        waitCycles(1);
        checkOutput("levelAfterPopWrite", fifo_level, 15);
        waitIdle(3000);
        checkOutput("popWriteRxCount", rxFrames.size() - rxBase, 17);

        $display("[TB] reset in the middle of a frame");
        sendEvent(1'b1, 1'b1, 8'h6B);
        sendEvent(1'b0, 1'b1, 8'h6B);
        waitTimer(9 * H + 1, 200);
        checkOutput("midBitClkLow", ps2_clk, 1'b0);
        checkOutput("midBitLevel", fifo_level, 4);
        reset_n = 1'b0;
        #1;
        checkOutput("resetClk", ps2_clk, 1'b1);
        checkOutput("resetData", ps2_data, 1'b1);
        checkOutput("resetLevel", fifo_level, 0);
        checkOutput("resetBusy", busy, 1'b0);
        waitCycles(3);
        reset_n = 1'b1;
        rxBase      = rxFrames.size();
        busyHighCnt = 0;
        waitCycles(300);
        checkOutput("postResetBusy", busyHighCnt, 0);
        checkOutput("postResetRx", rxFrames.size() - rxBase, 0);

        waitCycles(2);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
